// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: drives four hex-digit decoders. It runs a lamp test
// after reset or on request, holds the loaded digits, and supports
// blanking and blinking.
// Optional feature macro: LEADING_ZERO_BLANK_EN. When defined, leading-zero
// digits (3..1) are blanked in RUN. Digit 0 is never blanked.
module hex_display_ctrl #(
  parameter int unsigned TEST_CYCLES = 16,
  parameter int unsigned BLINK_W     = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load_valid,
  input  logic [15:0] load_data,
  output logic        load_ready,
  input  logic        display_en,
  input  logic        blink_en,
  input  logic        lamp_req,
  output logic [15:0] dig_data,
  output logic [3:0]  dig_blank,
  output logic [3:0]  dig_test,
  output logic        lamp_active
);

  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TEST_CYCLES - 1);

  typedef enum logic [1:0] {
    LAMP = 2'd0,
    RUN  = 2'd1,
    OFF  = 2'd2
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   lamp_cnt, lamp_cnt_nxt;
  logic [BLINK_W-1:0] blink_cnt, blink_nxt;
  logic [15:0]        data_nxt;
  logic [3:0]         blank_nxt, test_nxt, lzb_mask;
  logic               ready_nxt, lamp_nxt;

  // Leading-zero suppression mask, computed from the digit value that will be shown
  always_comb begin
    lzb_mask = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    lzb_mask[3] = (data_nxt[15:12] == 4'h0);
    lzb_mask[2] = (data_nxt[15:8]  == 8'h00);
    lzb_mask[1] = (data_nxt[15:4]  == 12'h000);
`endif
  end

  // Next state, counters, data capture and registered-output values
  always_comb begin
    state_nxt    = state;
    lamp_cnt_nxt = lamp_cnt;
    blink_nxt    = blink_cnt + BLINK_W'(1);
    data_nxt     = dig_data;
    ready_nxt    = 1'b0;
    test_nxt     = 4'b1111;
    blank_nxt    = 4'b0000;
    lamp_nxt     = 1'b1;

    if (load_valid && load_ready) begin
      data_nxt = load_data;
    end

    case (state)
      LAMP: begin
        if (lamp_cnt == LAST_CNT) begin
          state_nxt    = display_en ? RUN : OFF;
          lamp_cnt_nxt = '0;
        end else begin
          lamp_cnt_nxt = lamp_cnt + CNT_W'(1);
        end
      end
      RUN: begin
        if (lamp_req) begin
          state_nxt    = LAMP;
          lamp_cnt_nxt = '0;
        end else if (!display_en) begin
          state_nxt = OFF;
        end
      end
      OFF: begin
        if (lamp_req) begin
          state_nxt    = LAMP;
          lamp_cnt_nxt = '0;
        end else if (display_en) begin
          state_nxt = RUN;
        end
      end
      default: begin
        state_nxt    = LAMP;
        lamp_cnt_nxt = '0;
      end
    endcase

    // Outputs are precomputed from the next state so they register alongside it
    case (state_nxt)
      RUN: begin
        ready_nxt = 1'b1;
        test_nxt  = 4'b0000;
        lamp_nxt  = 1'b0;
        blank_nxt = (blink_en && blink_nxt[BLINK_W-1]) ? 4'b1111 : lzb_mask;
      end
      OFF: begin
        ready_nxt = 1'b1;
        test_nxt  = 4'b0000;
        lamp_nxt  = 1'b0;
        blank_nxt = 4'b1111;
      end
      default: begin
        ready_nxt = 1'b0;
        test_nxt  = 4'b1111;
        lamp_nxt  = 1'b1;
        blank_nxt = 4'b0000;
      end
    endcase
  end

  // State, counter, data and output registers with synchronous reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= LAMP;
      lamp_cnt    <= '0;
      blink_cnt   <= '0;
      dig_data    <= 16'h0000;
      load_ready  <= 1'b0;
      dig_test    <= 4'b1111;
      dig_blank   <= 4'b0000;
      lamp_active <= 1'b1;
    end else begin
      state       <= state_nxt;
      lamp_cnt    <= lamp_cnt_nxt;
      blink_cnt   <= blink_nxt;
      dig_data    <= data_nxt;
      load_ready  <= ready_nxt;
      dig_test    <= test_nxt;
      dig_blank   <= blank_nxt;
      lamp_active <= lamp_nxt;
    end
  end

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Testbench for hex_display_ctrl (TEST_CYCLES=16, BLINK_W=4).
// Stimulus queues the expected outputs per cycle. A negedge monitor compares them.
module tb_hex_display_ctrl;

  localparam int unsigned TC = 16;
  localparam int unsigned BW = 4;

  logic        clk = 1'b0;
  logic        reset_n, load_valid, load_ready, display_en, blink_en, lamp_req, lamp_active;
  logic [15:0] load_data, dig_data;
  logic [3:0]  dig_blank, dig_test;

  hex_display_ctrl #(.TEST_CYCLES(TC), .BLINK_W(BW)) dut (
    .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .display_en(display_en), .blink_en(blink_en),
    .lamp_req(lamp_req), .dig_data(dig_data), .dig_blank(dig_blank),
    .dig_test(dig_test), .lamp_active(lamp_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  test;
    logic        ready;
    logic        lamp;
  } exp_t;

  exp_t        exp_q[$];
  int          cyc = 0;
  int          rst_cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_data = 16'h0000;

  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(input string nm, input int c, input logic [15:0] act, input logic [15:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", nm, c, act, expv);
    end
  endtask

  // Monitor: compare every expectation scheduled for the current cycle
  always @(negedge clk) begin
    while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.cyc < cyc) begin
        checks++;
        errors++;
        $display("FAIL stale_expect cycle %0d: checked at %0d", e.cyc, cyc);
      end else begin
        chk("dig_data",    e.cyc, dig_data,           e.data);
        chk("dig_blank",   e.cyc, 16'(dig_blank),     16'(e.blank));
        chk("dig_test",    e.cyc, 16'(dig_test),      16'(e.test));
        chk("load_ready",  e.cyc, 16'(load_ready),    16'(e.ready));
        chk("lamp_active", e.cyc, 16'(lamp_active),   16'(e.lamp));
      end
    end
  end

  // Reference blanking in RUN, including the blink phase and zero suppression
  function automatic logic [3:0] run_blank(input logic [15:0] d, input int c, input logic ben);
    logic [BW-1:0] b;
    logic [3:0]    m;
    b = BW'(c - rst_cyc);
    if (ben && b[BW-1]) return 4'b1111;
    m = 4'b0000;
`ifdef LEADING_ZERO_BLANK_EN
    if (d[15:12] == 4'h0)   m[3] = 1'b1;
    if (d[15:8]  == 8'h00)  m[2] = 1'b1;
    if (d[15:4]  == 12'h0)  m[1] = 1'b1;
`endif
    return m;
  endfunction

  task automatic push(input logic [3:0] bl, input logic [3:0] te, input logic rd, input logic la);
    exp_t e;
    e.cyc = cyc; e.data = exp_data; e.blank = bl; e.test = te; e.ready = rd; e.lamp = la;
    exp_q.push_back(e);
  endtask

  task automatic exp_lamp(); push(4'b0000, 4'b1111, 1'b0, 1'b1); endtask
  task automatic exp_off();  push(4'b1111, 4'b0000, 1'b1, 1'b0); endtask
  task automatic exp_run();  push(run_blank(exp_data, cyc, blink_en), 4'b0000, 1'b1, 1'b0); endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; load_valid = 1'b0; load_data = 16'h0000;
    display_en = 1'b1; blink_en = 1'b0; lamp_req = 1'b0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      step(); rst_cyc = cyc; exp_lamp();
    end

    // Lamp test: 16 cycles total including the reset cycle. Loads are refused.
    reset_n = 1'b1; load_valid = 1'b1; load_data = 16'h1234;
    for (int i = 0; i < int'(TC) - 1; i++) begin
      step(); exp_lamp();
      if (i == 6) load_valid = 1'b0;
    end
    step(); exp_run();

    // Load in RUN, then hold
    load_valid = 1'b1; load_data = 16'hBEEF;
    step(); exp_data = 16'hBEEF; exp_run();
    load_valid = 1'b0; load_data = 16'h5555;
    step(); exp_run();

    // display_en fall -> OFF. A load is accepted in OFF. Rise -> RUN.
    display_en = 1'b0;
    step(); exp_off();
    load_valid = 1'b1; load_data = 16'h0007;
    step(); exp_data = 16'h0007; exp_off();
    load_valid = 1'b0; display_en = 1'b1;
    step(); exp_run();
    load_valid = 1'b1; load_data = 16'h0000;
    step(); exp_data = 16'h0000; exp_run();
    load_data = 16'hBEEF;
    step(); exp_data = 16'hBEEF; exp_run();
    load_valid = 1'b0;

    // Blink: 24 cycles cover at least one full blink-off half-period
    blink_en = 1'b1;
    for (int i = 0; i < 24; i++) begin
      step(); exp_run();
    end
    blink_en = 1'b0;
    step(); exp_run();

    // lamp_req with a simultaneous load. A second request during LAMP is ignored.
    lamp_req = 1'b1; load_valid = 1'b1; load_data = 16'h00A5;
    step(); exp_data = 16'h00A5; exp_lamp();
    lamp_req = 1'b0; load_valid = 1'b0;
    for (int i = 0; i < int'(TC) - 1; i++) begin
      step(); exp_lamp();
      lamp_req = (i == 4);
    end
    lamp_req = 1'b0;
    step(); exp_run();

    // lamp_req from OFF returns to OFF when display_en is low
    display_en = 1'b0;
    step(); exp_off();
    lamp_req = 1'b1;
    step(); exp_lamp();
    lamp_req = 1'b0;
    for (int i = 0; i < int'(TC) - 1; i++) begin
      step(); exp_lamp();
    end
    step(); exp_off();

    // Reset mid-operation takes priority over load and lamp_req
    display_en = 1'b1; reset_n = 1'b0; load_valid = 1'b1; load_data = 16'hFFFF; lamp_req = 1'b1;
    step(); rst_cyc = cyc; exp_data = 16'h0000; exp_lamp();
    reset_n = 1'b1; load_valid = 1'b0; lamp_req = 1'b0;
    step(); exp_lamp();

    // Drain the scoreboard
    step(); step();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations pending, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the bench always terminates
  initial begin
    #100000;
    $display("FAIL timeout: reached time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hex_display_ctrl.md
HEX_DISPLAY_CTRL -- requirements
Module: hex_display_ctrl

Interface
REQ-001 SHALL provide parameter TEST_CYCLES, default 16: lamp-test duration in clk cycles (legal range 1..65535).
REQ-002 SHALL provide parameter BLINK_W, default 8: blink counter width; blink half-period is 2^(BLINK_W-1) cycles.
REQ-003 SHALL provide port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 SHALL provide port reset_n, input, 1 bit: synchronous, active-low reset, sampled on the rising clk edge.
REQ-005 SHALL provide port load_valid, input, 1 bit: requester offers load_data.
REQ-006 SHALL provide port load_data, input, 16 bits: four hex digits; [3:0] is digit 0, the rightmost.
REQ-007 SHALL provide port load_ready, output, 1 bit: controller can accept a load.
REQ-008 SHALL provide port display_en, input, 1 bit: 1 = show digits, 0 = all digits blank.
REQ-009 SHALL provide port blink_en, input, 1 bit: 1 = blank all digits during the blink-off half-period.
REQ-010 SHALL provide port lamp_req, input, 1 bit: single-cycle pulse that restarts the lamp test.
REQ-011 SHALL provide port dig_data, output, 16 bits: nibble i drives the dataIn input of digit-i decoder.
REQ-012 SHALL provide port dig_blank, output, 4 bits: bit i drives the blank input of digit-i decoder.
REQ-013 SHALL provide port dig_test, output, 4 bits: bit i drives the test input of digit-i decoder.
REQ-014 SHALL provide port lamp_active, output, 1 bit: 1 while in state LAMP.

Function
REQ-015 SHALL implement a state machine with three states: LAMP, RUN, OFF.
REQ-016 LAMP: dig_test=4'b1111, dig_blank=4'b0000, load_ready=0, and a cycle counter increments each cycle.
REQ-017 LAMP exit: when the counter equals TEST_CYCLES-1, next state SHALL be RUN if display_en=1, else OFF; the counter SHALL clear.
REQ-018 RUN: dig_test=0 and load_ready=1; dig_blank is per REQ-022..024; display_en=0 SHALL move to OFF next cycle.
REQ-019 OFF: dig_test=0, dig_blank=4'b1111, load_ready=1; display_en=1 SHALL move to RUN next cycle.
REQ-020 lamp_req=1 in RUN or OFF SHALL move to LAMP with counter 0; lamp_req SHALL have priority over display_en transitions and SHALL be ignored in LAMP (no restart).
REQ-021 A load SHALL complete on any edge with load_valid & load_ready; dig_data SHALL equal load_data from that edge on and be held otherwise. A load in the same cycle as lamp_req SHALL be accepted and retained.
REQ-022 A free-running BLINK_W-bit counter SHALL increment every cycle in all states and wrap from all-ones to 0; blink-off phase = counter MSB = 1.
REQ-023 In RUN with blink_en=1 during blink-off phase, dig_blank SHALL be 4'b1111; blink_en SHALL have no effect in LAMP or OFF.
REQ-024 In RUN otherwise, dig_blank SHALL be 4'b0000, except as modified by REQ-029.
REQ-025 dig_blank, dig_test, lamp_active and load_ready SHALL be functions of registered state only (no combinational path from any input), valid the cycle after each state change.

Reset
REQ-026 reset_n=0 at a clock edge SHALL force state LAMP, lamp counter 0, blink counter 0, dig_data=16'h0000, regardless of operation in progress.
REQ-027 Outputs during and immediately after reset SHALL be dig_test=4'b1111, dig_blank=4'b0000, load_ready=0, lamp_active=1.
REQ-028 Reset SHALL take priority over load, lamp_req and all transitions.

Configuration
REQ-029 With macro LEADING_ZERO_BLANK_EN defined, in RUN digit i (i=3,2,1) SHALL additionally be blanked when nibble i and all higher nibbles of dig_data are 0; digit 0 is never suppressed.
REQ-030 Without LEADING_ZERO_BLANK_EN, no zero suppression SHALL occur; all four digits show in RUN outside blink-off.

Verification
REQ-031 Reset then display_en=1, TEST_CYCLES=16 -> dig_test=1111 and load_ready=0 for exactly 16 cycles, then RUN with dig_test=0000 and load_ready=1.
REQ-032 In RUN, load_valid=1, load_data=16'hBEEF -> dig_data=16'hBEEF from the accepting edge; in LAMP, load_valid with 16'h1234 -> not accepted and dig_data unchanged.
REQ-033 In RUN, display_en 1->0->1 -> dig_blank=1111 the cycle after the fall, 0000 the cycle after the rise.
REQ-034 In RUN, blink_en=1, BLINK_W=4 -> dig_blank toggles between 0000 and 1111 every 8 cycles.
REQ-035 In RUN, lamp_req pulse together with a load of 16'h00A5 -> LAMP for TEST_CYCLES cycles; afterwards dig_data=16'h00A5.
REQ-036 dig_data=16'h0007 in RUN -> dig_blank=1110 with LEADING_ZERO_BLANK_EN and 0000 without; 16'h0000 -> 1110 with the macro.
